// File: rtl/dmem_bridge.sv
`default_nettype none
// ============================================================================
// Module   : dmem_bridge
// Purpose  : CPU data-memory bridge. Accepts one load/store request at a time
//            and completes it through a three-state sequence
//            (IDLE -> ACCESS -> RESP). It serves an 8 KiB word-organised RAM,
//            a byte-writable LED register and a free-running read-only cycle
//            counter.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk    in   1   clock, all state updates on the rising edge
//   reset  in   1   synchronous active-high reset
//   req    in   1   access request, sampled only in IDLE
//   we     in   1   1 = store, 0 = load
//   size   in   2   00 word, 01 halfword, 10 byte, 11 reserved
//   addr   in  32   byte address
//   wdata  in  32   store data, right-aligned
//   rdata  out 32   load data, right-aligned, zero-filled, valid with ready
//   ready  out  1   single-cycle completion pulse
//   error  out  1   misaligned / reserved size / unmapped, valid with ready
//   led    out 32   LED register contents
// ----------------------------------------------------------------------------
// Parameters
//   CNT_PRESET  value loaded into the cycle counter by reset (0 normally)
// ============================================================================
module dmem_bridge #(
  parameter logic [31:0] CNT_PRESET = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        error,
  output logic [31:0] led
);

  // Address map: RAM window 0x1001_0000..0x1001_1FFF shares addr[31:13];
  // the two MMIO registers are matched on their word address addr[31:2].
  localparam logic [18:0] C_RAM_TAG   = 19'h0_8008;
  localparam logic [29:0] C_LED_WADDR = 30'h0400_8000;
  localparam logic [29:0] C_CNT_WADDR = 30'h0400_8001;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  // Request decode (combinational, from the live CPU inputs)
  logic        w_misalign;
  logic [3:0]  w_be;
  logic [31:0] w_wd;
  logic        w_ram_hit;
  logic        w_led_hit;
  logic        w_cnt_hit;
  logic        w_dec_err;
  logic        w_accept;

  // Latched request
  logic        r_we;
  logic [1:0]  r_size;
  logic [1:0]  r_off;
  logic [10:0] r_idx;
  logic [3:0]  r_be;
  logic [31:0] r_wd;
  logic        r_err;
  logic        r_sel_ram;
  logic        r_sel_led;
  logic        r_sel_cnt;

  // Access stage
  logic        w_do_access;
  logic        w_ram_wr;
  logic        w_led_wr;
  logic [31:0] r_mem [0:2047];
  logic [31:0] r_ram_q;
  logic [31:0] r_mmio_q;
  logic [31:0] r_led;
  logic [31:0] r_cnt;

  // Load extraction
  logic [31:0] w_word;
  logic [31:0] w_shifted;
  logic [31:0] w_lmask;
  logic [31:0] w_load;

  // --------------------------------------------------------------------------
  // Decode: alignment, byte enables and lane replication of store data.
  // Replicating the data onto every lane lets the byte enables alone pick
  // the bytes that land in the target word.
  // --------------------------------------------------------------------------
  always_comb begin
    w_misalign = 1'b0;
    w_be       = 4'b0000;
    w_wd       = wdata;
    case (size)
      2'b00: begin
        w_misalign = (addr[1:0] != 2'b00);
        w_be       = 4'b1111;
        w_wd       = wdata;
      end
      2'b01: begin
        w_misalign = addr[0];
        w_be       = addr[1] ? 4'b1100 : 4'b0011;
        w_wd       = {2{wdata[15:0]}};
      end
      2'b10: begin
        w_misalign = 1'b0;
        w_be       = 4'b0001 << addr[1:0];
        w_wd       = {4{wdata[7:0]}};
      end
      default: begin
        // Reserved size is reported the same way as a misaligned access.
        w_misalign = 1'b1;
      end
    endcase
  end

  assign w_ram_hit = (addr[31:13] == C_RAM_TAG);
  assign w_led_hit = (addr[31:2] == C_LED_WADDR);
  assign w_cnt_hit = (addr[31:2] == C_CNT_WADDR);
  assign w_dec_err = w_misalign | ~(w_ram_hit | w_led_hit | w_cnt_hit);
  assign w_accept  = (r_state == S_IDLE) && req;

  // --------------------------------------------------------------------------
  // Request latch: captured once in IDLE, held through ACCESS and RESP so
  // that changes on the CPU bus during the access have no effect.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_we      <= 1'b0;
      r_size    <= 2'b00;
      r_off     <= 2'b00;
      r_idx     <= 11'd0;
      r_be      <= 4'b0000;
      r_wd      <= 32'h0000_0000;
      r_err     <= 1'b0;
      r_sel_ram <= 1'b0;
      r_sel_led <= 1'b0;
      r_sel_cnt <= 1'b0;
    end else if (w_accept) begin
      r_we      <= we;
      r_size    <= size;
      r_off     <= addr[1:0];
      r_idx     <= addr[12:2];
      r_be      <= w_be;
      r_wd      <= w_wd;
      r_err     <= w_dec_err;
      r_sel_ram <= w_ram_hit;
      r_sel_led <= w_led_hit;
      r_sel_cnt <= w_cnt_hit;
    end
  end

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    ready       = 1'b0;
    error       = 1'b0;
    rdata       = 32'h0000_0000;
    case (r_state)
      S_IDLE: begin
        if (req) begin
          w_state_nxt = S_ACCESS;
        end
      end
      S_ACCESS: begin
        w_state_nxt = S_RESP;
      end
      S_RESP: begin
        w_state_nxt = S_IDLE;
        // An access interrupted by reset must not complete, so the response
        // is suppressed while reset is high even before the edge takes it.
        if (!reset) begin
          ready = 1'b1;
          error = r_err;
          rdata = (r_err || r_we) ? 32'h0000_0000 : w_load;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Access stage. Qualifying with reset keeps a store whose ACCESS edge
  // coincides with reset from being committed.
  // --------------------------------------------------------------------------
  assign w_do_access = (r_state == S_ACCESS) && !reset;
  assign w_ram_wr    = w_do_access && r_we && r_sel_ram && !r_err;
  assign w_led_wr    = w_do_access && r_we && r_sel_led && !r_err;

  // RAM with registered read port; contents survive reset.
  always_ff @(posedge clk) begin
    if (w_ram_wr) begin
      for (int b = 0; b < 4; b++) begin
        if (r_be[b]) begin
          r_mem[r_idx][8*b +: 8] <= r_wd[8*b +: 8];
        end
      end
    end
    if (w_do_access) begin
      r_ram_q <= r_mem[r_idx];
    end
  end

  // LED register, cycle counter and MMIO read snapshot.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_led    <= 32'h0000_0000;
      r_cnt    <= CNT_PRESET;
      r_mmio_q <= 32'h0000_0000;
    end else begin
      r_cnt <= r_cnt + 32'd1;
      if (w_led_wr) begin
        for (int b = 0; b < 4; b++) begin
          if (r_be[b]) begin
            r_led[8*b +: 8] <= r_wd[8*b +: 8];
          end
        end
      end
      if (w_do_access) begin
        r_mmio_q <= r_sel_cnt ? r_cnt : r_led;
      end
    end
  end

  assign led = r_led;

  // --------------------------------------------------------------------------
  // Load extraction: move the addressed byte/half down to bit 0 and clear
  // everything above it.
  // --------------------------------------------------------------------------
  always_comb begin
    w_word    = r_sel_ram ? r_ram_q : r_mmio_q;
    w_shifted = w_word >> {r_off, 3'b000};
    case (r_size)
      2'b00:   w_lmask = 32'hFFFF_FFFF;
      2'b01:   w_lmask = 32'h0000_FFFF;
      2'b10:   w_lmask = 32'h0000_00FF;
      default: w_lmask = 32'h0000_0000;
    endcase
    w_load = w_shifted & w_lmask;
  end

endmodule
`default_nettype wire

// File: doc/dmem_bridge.md
DMEM_BRIDGE -- requirements
Module: dmem_bridge

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 reset  input  1  synchronous, active-high reset; sampled on rising edge of clk only.
REQ-003 req  input  1  CPU access request; sampled only in IDLE.
REQ-004 we  input  1  1 = store, 0 = load; sampled with req.
REQ-005 size  input  2  access width: 00 word, 01 halfword, 10 byte, 11 reserved (treated as misaligned).
REQ-006 addr  input  32  byte address from CPU Z register.
REQ-007 wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-008 rdata  output  32  load data, right-aligned, upper unused bits zero; sign/zero extension is done by the CPU load-transform stage.
REQ-009 ready  output  1  one-cycle pulse: access complete, rdata/error valid this cycle.
REQ-010 error  output  1  valid with ready: misaligned, reserved size, or unmapped address.
REQ-011 led  output  32  MMIO LED register contents.

Function
REQ-012 Address map: RAM 0x1001_0000-0x1001_1FFF (2048 x 32-bit words, index addr[12:2]); LED register 0x1002_0000 (R/W); cycle counter 0x1002_0004 (read-only); all else unmapped.
REQ-013 FSM states IDLE, ACCESS, RESP; reset state IDLE.
REQ-014 IDLE: on req=1, latch we, size, addr, wdata, decode result; go to ACCESS; req=0 stays IDLE.
REQ-015 ACCESS: perform RAM read or byte-enabled RAM/LED write exactly once; go to RESP.
REQ-016 RESP: ready=1 for this single cycle, rdata/error driven from latched result; go to IDLE.
REQ-017 Latency: req sampled in cycle N -> ready=1 in cycle N+2; next req accepted no earlier than N+3.
REQ-018 req asserted in ACCESS or RESP is ignored; CPU holds req until ready.
REQ-019 Alignment: word requires addr[1:0]=00; halfword requires addr[0]=0; byte any.
REQ-020 Store byte enables: word 1111; halfword 0011 (addr[1]=0) or 1100 (addr[1]=1); byte lane addr[1:0]; wdata replicated onto selected lane(s); unselected bytes unchanged.
REQ-021 Load extraction: selected byte/half shifted to bit 0, remaining bits zero.
REQ-022 Any error condition: no RAM/LED modification, rdata=0, error=1 with ready.
REQ-023 Store to cycle counter: error=0, ignored (no state change).
REQ-024 Cycle counter: 32-bit, +1 every cycle after reset, wraps 0xFFFF_FFFF -> 0; load returns value latched in ACCESS cycle.
REQ-025 LED writes obey byte enables as RAM; led output reflects new value the cycle after ACCESS.
REQ-026 Load from RAM uses registered (synchronous) RAM read in ACCESS; result held for RESP.
REQ-027 ready=0 and error=0 whenever not in RESP; rdata=0 outside RESP.

Reset
REQ-028 reset=1: state IDLE, ready=0, error=0, rdata=0, led=0, cycle counter=0; latched request discarded.
REQ-029 Reset mid-access (ACCESS or RESP): no ready pulse issued; a store whose ACCESS edge coincides with reset is not committed.
REQ-030 RAM contents are not cleared by reset.

Verification
REQ-031 sw 0xDEADBEEF @0x1001_0010 then lw @0x1001_0010 -> ready 2 cycles after each req, rdata=0xDEADBEEF, error=0.
REQ-032 sb 0x55 @0x1001_0013 over 0xDEADBEEF, then lw -> 0x55ADBEEF; lb @0x1001_0013 -> rdata=0x0000_0055.
REQ-033 sh @0x1001_0011 and lw @0x1001_0012 -> error=1, rdata=0, memory unchanged; size=11 -> error=1.
REQ-034 lw @0x2000_0000 -> error=1, rdata=0; sw 0x0000_00FF @0x1002_0000 -> led=0xFF; sw to 0x1002_0004 -> error=0, counter unaffected.
REQ-035 Two lw of 0x1002_0004 spaced K cycles apart -> difference equals K; counter forced near 0xFFFF_FFFF wraps to 0.
REQ-036 reset asserted in ACCESS of sw -> no ready pulse, target word unchanged, led=0, next req completes normally.
